// File: rtl/store_pack_unit.sv
// Store packer for the MEM stage: lane-replicates store data, builds byte enables,
// rejects misaligned/reserved stores and queues legal ones toward data memory.
module store_pack_unit #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [1:0]    req_sop,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          exc_ades,
    output logic [AW-1:0] exc_addr,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; ready never looks at valid, and req_ready never looks at mem_ready.

    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [1:0]    a;
    logic          legal;
    logic [31:0]   pk_data;
    logic [3:0]    pk_be;
    logic          accept;
    logic          enq;
    logic          deq;

    assign a = req_addr[1:0];

    always_comb begin
        legal   = 1'b0;
        pk_data = req_wdata;
        pk_be   = 4'b0000;
        case (req_sop)
            2'b00: begin
                legal = (a == 2'b00);
                pk_be = 4'b1111;
            end
            2'b01: begin
                legal   = !a[0];
                pk_data = {2{req_wdata[15:0]}};
                pk_be   = a[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal   = 1'b1;
                pk_data = {4{req_wdata[7:0]}};
                pk_be   = 4'b0001 << a;
            end
            default: legal = 1'b0;
        endcase
    end

    assign req_ready = (count != CW'(DEPTH));
    assign empty     = (count == '0);
    assign mem_valid = !empty;
    assign accept    = req_valid && req_ready;
    assign enq       = accept && legal;
    assign deq       = mem_valid && mem_ready;

    assign mem_addr  = addr_q[rd_ptr];
    assign mem_wdata = data_q[rd_ptr];
    assign mem_be    = be_q[rd_ptr];

    // Storage is not reset: count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr] <= {req_addr[AW-1:2], 2'b00};
            data_q[wr_ptr] <= pk_data;
            be_q[wr_ptr]   <= pk_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            exc_ades <= 1'b0;
            exc_addr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            exc_ades <= accept && !legal;
            if (accept && !legal) exc_addr <= req_addr;
        end
    end

endmodule

// File: tb/tb_store_pack_unit.sv
// Bench for store_pack_unit: queue-based reference model checked every cycle,
// directed literal cases, then randomized traffic.
module tb_store_pack_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_sop = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        exc_ades;
    logic [31:0] exc_addr;
    logic        empty;

    store_pack_unit #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sop(req_sop),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .exc_ades(exc_ades), .exc_addr(exc_addr), .empty(empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entries are {word_addr, wdata, be}
    logic [67:0] exp_q[$];
    logic        m_exc = 1'b0;
    logic [31:0] m_exc_addr = '0;
    logic        started = 1'b0;

    function automatic logic [67:0] pack(input logic [31:0] ad, input logic [31:0] d,
                                         input logic [1:0] s, output logic ok);
        logic [31:0] w;
        logic [3:0]  be;
        int          off;
        off = int'(ad % 4);
        ok  = 1'b0;
        w   = d;
        be  = 4'b0000;
        if (s == 2'd0) begin
            ok = (off == 0); be = 4'hF;
        end else if (s == 2'd1) begin
            ok = (off % 2 == 0);
            w  = (d & 32'hFFFF) * 32'h0001_0001;
            be = (off >= 2) ? 4'hC : 4'h3;
        end else if (s == 2'd2) begin
            ok = 1'b1;
            w  = (d & 32'hFF) * 32'h0101_0101;
            be = 4'(1 << off);
        end
        return {ad - 32'(off), w, be};
    endfunction

    always @(posedge clk) begin
        logic acc, dq, ok;
        logic [67:0] ent;
        if (reset) begin
            exp_q.delete();
            m_exc = 1'b0;
            m_exc_addr = '0;
        end else begin
            acc = req_valid && (exp_q.size() < DEPTH);
            dq  = (exp_q.size() != 0) && mem_ready;
            ent = pack(req_addr, req_wdata, req_sop, ok);
            m_exc = acc && !ok;
            if (m_exc) m_exc_addr = req_addr;
            if (dq) void'(exp_q.pop_front());
            if (acc && ok) exp_q.push_back(ent);
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("mem_valid", 68'(mem_valid), 68'(exp_q.size() != 0));
            check("empty", 68'(empty), 68'(exp_q.size() == 0));
            check("req_ready", 68'(req_ready), 68'(exp_q.size() < DEPTH));
            check("exc_ades", 68'(exc_ades), 68'(m_exc));
            check("exc_addr", 68'(exc_addr), 68'(m_exc_addr));
            if (exp_q.size() != 0)
                check("head", {mem_addr, mem_wdata, mem_be}, exp_q[0]);
        end
    end

    task automatic drive(input logic v, input logic [31:0] ad, input logic [31:0] d,
                         input logic [1:0] s, input logic mr);
        req_valid = v;
        req_addr  = ad;
        req_wdata = d;
        req_sop   = s;
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    endtask

    initial begin
        // clock/reset
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        reset = 1'b0;
        check("rst_mem_valid", 68'(mem_valid), 68'd0);
        check("rst_empty", 68'(empty), 68'd1);
        check("rst_req_ready", 68'(req_ready), 68'd1);
        check("rst_exc_ades", 68'(exc_ades), 68'd0);
        check("rst_exc_addr", 68'(exc_addr), 68'd0);

        // sb at byte 3
        drive(1'b1, 32'h1003, 32'h0000_00AB, 2'b10, 1'b0);
        check("sb_addr", 68'(mem_addr), 68'h1000);
        check("sb_wdata", 68'(mem_wdata), 68'hABAB_ABAB);
        check("sb_be", 68'(mem_be), 68'h8);
        idle(2);

        // sh upper half, sw, then full-FIFO contention with mem_ready
        drive(1'b1, 32'h2002, 32'h1234_CDEF, 2'b01, 1'b0);
        check("sh_wdata", 68'(mem_wdata), 68'hCDEF_CDEF);
        check("sh_be", 68'(mem_be), 68'hC);
        drive(1'b1, 32'h2004, 32'h1122_3344, 2'b00, 1'b0);
        check("full_ready", 68'(req_ready), 68'd0);
        check("full_hold", 68'(mem_wdata), 68'hCDEF_CDEF);
        drive(1'b1, 32'h2008, 32'hAAAA_5555, 2'b00, 1'b0);
        check("stall_hold", 68'(mem_be), 68'hC);
        drive(1'b1, 32'h2008, 32'hAAAA_5555, 2'b00, 1'b1);
        check("freed_ready", 68'(req_ready), 68'd1);
        check("sw_addr", 68'(mem_addr), 68'h2004);
        check("sw_be", 68'(mem_be), 68'hF);
        drive(1'b1, 32'h2008, 32'hAAAA_5555, 2'b00, 1'b0);
        check("retry_full", 68'(req_ready), 68'd0);
        idle(3);
        check("drained", 68'(empty), 68'd1);

        // misaligned sh and reserved sop
        drive(1'b1, 32'h3001, 32'h5555_5555, 2'b01, 1'b0);
        check("ades_sh", 68'(exc_ades), 68'd1);
        check("ades_sh_addr", 68'(exc_addr), 68'h3001);
        check("ades_sh_nq", 68'(mem_valid), 68'd0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        check("ades_pulse", 68'(exc_ades), 68'd0);
        check("ades_hold", 68'(exc_addr), 68'h3001);
        drive(1'b1, 32'h3004, 32'h1, 2'b11, 1'b0);
        check("ades_rsv", 68'(exc_ades), 68'd1);
        check("ades_rsv_addr", 68'(exc_addr), 68'h3004);
        check("ades_rsv_nq", 68'(mem_valid), 68'd0);

        // reset with two entries pending
        drive(1'b1, 32'h4000, 32'h0101_0101, 2'b00, 1'b0);
        drive(1'b1, 32'h4004, 32'h0202_0202, 2'b00, 1'b0);
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        reset = 1'b0;
        check("rst2_valid", 68'(mem_valid), 68'd0);
        check("rst2_empty", 68'(empty), 68'd1);
        drive(1'b1, 32'h4008, 32'hDEAD_BEEF, 2'b00, 1'b0);
        check("post_rst_valid", 68'(mem_valid), 68'd1);
        check("post_rst_data", 68'(mem_wdata), 68'hDEAD_BEEF);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom & 32'h0000_FFFF, $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                drive(1'b0, 32'h0, 32'h0, 2'b00, 1'($urandom_range(0, 1)));
                reset = 1'b0;
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
